// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: memory read port toward `memory` and the
// instruction handshake toward decode.
interface fetch_unit_if;
   logic [31:0] mem_address;
   logic [1:0]  mem_access_size;
   logic        mem_rw;
   logic        mem_enable;
   logic        mem_busy;
   logic [31:0] mem_data_out;
   logic [31:0] insn;
   logic [31:0] insn_pc;
   logic        insn_valid;
   logic        insn_ready;

   modport master (
      output mem_address, mem_access_size, mem_rw, mem_enable,
      input  mem_busy, mem_data_out,
      output insn, insn_pc, insn_valid,
      input  insn_ready
   );

   modport slave (
      input  mem_address, mem_access_size, mem_rw, mem_enable,
      output mem_busy, mem_data_out,
      input  insn, insn_pc, insn_valid,
      output insn_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: walks a word-aligned PC, issues single-word reads,
// and hands each returned word to decode over a valid/ready handshake.
module fetch_unit #(
   parameter logic [31:0] START_ADDR = 32'h8002_0000,
   parameter int unsigned MEM_DEPTH  = 1048576
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         start,
   input  logic [31:0]  insn_count,
   input  logic         redirect,
   input  logic [31:0]  redirect_pc,
   fetch_unit_if.master bus,
   output logic         done,
   output logic         error
);

   typedef enum logic [2:0] {IDLE, REQ, RESP, HOLD, DONE} state_t;

   localparam logic [31:0] LAST_OFFSET = 32'(MEM_DEPTH - 32'd4);

   state_t      state, state_d;
   logic [31:0] pc, pc_d;
   logic [31:0] remaining, remaining_d;
   logic [31:0] insn_q, insn_d;
   logic [31:0] insn_pc_q, insn_pc_d;
   logic        valid_q, valid_d;
   logic        done_d, error_d;
   logic        mem_en;
   logic        pc_in_range;
   logic [31:0] redirect_target;

   // Unsigned offset compare also rejects PCs below the window (they wrap high).
   assign pc_in_range     = (pc - START_ADDR) <= LAST_OFFSET;
   assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         pc        <= START_ADDR;
         remaining <= '0;
         insn_q    <= '0;
         insn_pc_q <= '0;
         valid_q   <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         state     <= state_d;
         pc        <= pc_d;
         remaining <= remaining_d;
         insn_q    <= insn_d;
         insn_pc_q <= insn_pc_d;
         valid_q   <= valid_d;
         done      <= done_d;
         error     <= error_d;
      end
   end

   always_comb begin
      state_d     = state;
      pc_d        = pc;
      remaining_d = remaining;
      insn_d      = insn_q;
      insn_pc_d   = insn_pc_q;
      valid_d     = valid_q;
      done_d      = done;
      error_d     = error;
      mem_en      = 1'b0;

      // Redirect outranks busy, ready and the range check, so no request
      // is ever presented in a redirect cycle.
      if (redirect && (state == REQ || state == RESP || state == HOLD)) begin
         pc_d    = redirect_target;
         valid_d = 1'b0;
         state_d = REQ;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  pc_d        = START_ADDR;
                  remaining_d = insn_count;
                  error_d     = 1'b0;
                  done_d      = (insn_count == '0);
                  state_d     = (insn_count == '0) ? DONE : REQ;
               end
            end
            REQ: begin
               if (!pc_in_range) begin
                  error_d = 1'b1;
                  done_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  mem_en = 1'b1;
                  if (!bus.mem_busy) state_d = RESP;
               end
            end
            RESP: begin
               insn_d    = bus.mem_data_out;
               insn_pc_d = pc;
               valid_d   = 1'b1;
               pc_d      = pc + 32'd4;
               if (remaining != '0) remaining_d = remaining - 32'd1;
               state_d   = HOLD;
            end
            HOLD: begin
               if (bus.insn_ready) begin
                  valid_d = 1'b0;
                  if (remaining == '0) begin
                     done_d  = 1'b1;
                     state_d = DONE;
                  end else begin
                     state_d = REQ;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign bus.mem_address     = pc;
   assign bus.mem_access_size = 2'b00;
   assign bus.mem_rw          = 1'b1;
   assign bus.mem_enable      = mem_en;
   assign bus.insn            = insn_q;
   assign bus.insn_pc         = insn_pc_q;
   assign bus.insn_valid      = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a word-level program model predicts the
// delivered (pc, word) stream; a posedge monitor checks every handshake.
module tb_fetch_unit;
   localparam logic [31:0] START = 32'h8002_0000;
   localparam int unsigned DEPTH = 1048576;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } item_t;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] insn_count = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        done, error;

   fetch_unit_if mif();

   fetch_unit #(.START_ADDR(START), .MEM_DEPTH(DEPTH)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .insn_count  (insn_count),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .bus         (mif),
      .done        (done),
      .error       (error)
   );

   initial forever #5 clock = ~clock;

   int n_checks = 0;
   int n_pass = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: actual %h, required %h", name, act, req);
   endfunction

   // Memory image: explicit words where loaded, otherwise an address hash.
   logic [31:0] ovr [logic [31:0]];
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (ovr.exists(a)) return ovr[a];
      return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1F0E};
   endfunction

   int accept_cnt = 0;
   bit in_resp = 1'b0;
   always @(posedge clock) begin
      if (start) accept_cnt = 0;
      in_resp = mif.mem_enable && !mif.mem_busy;
      if (in_resp) begin
         accept_cnt++;
         mif.mem_data_out <= mem_word(mif.mem_address);
      end
   end

   // Scoreboard and interface-property monitor
   item_t       exp_q[$];
   logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_redir = 1'b0;
   logic        prev_en = 1'b0, prev_busy = 1'b0;
   logic [31:0] prev_insn = '0, prev_ipc = '0, prev_addr = '0;
   always @(posedge clock) begin
      if (mif.insn_valid && mif.insn_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL extra_word: actual pc %h, required no delivery", mif.insn_pc);
         end else begin
            item_t e;
            e = exp_q.pop_front();
            chk("insn_pc", mif.insn_pc, e.pc);
            chk("insn", mif.insn, e.data);
         end
      end
      if (prev_valid && !prev_ready && !prev_redir && mif.insn_valid) begin
         chk("stall_insn", mif.insn, prev_insn);
         chk("stall_insn_pc", mif.insn_pc, prev_ipc);
      end
      if (prev_en && prev_busy && mif.mem_enable)
         chk("busy_addr", mif.mem_address, prev_addr);
      if (mif.mem_enable)
         chk("addr_window", 32'(longint'(mif.mem_address) >= longint'(START) &&
             longint'(mif.mem_address) <= longint'(START) + longint'(DEPTH) - 4), 32'd1);
      prev_valid <= mif.insn_valid;
      prev_ready <= mif.insn_ready;
      prev_redir <= redirect;
      prev_insn  <= mif.insn;
      prev_ipc   <= mif.insn_pc;
      prev_en    <= mif.mem_enable;
      prev_busy  <= mif.mem_busy;
      prev_addr  <= mif.mem_address;
   end

   // Redirect plan, keyed by fetch number (kind 2: drop in flight, 3: drop held word)
   int          ev_kind [64];
   logic [31:0] ev_tgt [64];
   bit          req_redir;
   logic [31:0] req_tgt;

   task automatic clear_plan();
      for (int f = 0; f < 64; f++) begin
         ev_kind[f] = 0;
         ev_tgt[f]  = '0;
      end
      req_redir = 1'b0;
      req_tgt   = '0;
   endtask

   // Program-level model: which words reach decode and whether the run errors.
   task automatic build_expected(input int n, output bit err);
      logic [31:0] pc;
      logic [31:0] rem;
      logic [31:0] w;
      item_t       e;
      int          k;
      err = 1'b0;
      rem = n;
      pc  = req_redir ? (req_tgt & 32'hFFFF_FFFC) : START;
      if (n == 0) return;
      for (int f = 0; f < 60; f++) begin
         if (longint'(pc) < longint'(START) || longint'(pc) > longint'(START) + longint'(DEPTH) - 4) begin
            err = 1'b1;
            return;
         end
         w = pc;
         k = ev_kind[f];
         if (k == 2) begin
            pc = ev_tgt[f] & 32'hFFFF_FFFC;
            continue;
         end
         if (rem != 0) rem = rem - 1;
         pc = pc + 4;
         if (k == 3) begin
            pc = ev_tgt[f] & 32'hFFFF_FFFC;
            continue;
         end
         e.pc   = w;
         e.data = mem_word(w);
         exp_q.push_back(e);
         if (rem == 0) return;
      end
   endtask

   task automatic do_run(input string tag, input int n, input bit rnd, input int bp_cycles,
                         input int busy_cycles, input int exp_done_edge);
      bit err_exp;
      int i;
      build_expected(n, err_exp);
      @(negedge clock);
      start       = 1'b1;
      insn_count  = n;
      redirect    = 1'b0;
      for (i = 1; i <= 400; i++) begin
         @(negedge clock);
         start = 1'b0;
         if (done) break;
         redirect = 1'b0;
         if (rnd) begin
            mif.mem_busy   = ($urandom_range(0, 2) == 0);
            mif.insn_ready = ($urandom_range(0, 2) != 0);
         end else begin
            mif.mem_busy   = (i <= busy_cycles);
            mif.insn_ready = !(i >= 3 && i < 3 + bp_cycles);
         end
         if (i == 1 && req_redir) begin
            redirect = 1'b1;
            redirect_pc = req_tgt;
         end else if (in_resp && accept_cnt > 0 && accept_cnt <= 64 && ev_kind[accept_cnt-1] == 2) begin
            redirect = 1'b1;
            redirect_pc = ev_tgt[accept_cnt-1];
         end else if (mif.insn_valid && accept_cnt > 0 && accept_cnt <= 64 && ev_kind[accept_cnt-1] == 3) begin
            redirect = 1'b1;
            redirect_pc = ev_tgt[accept_cnt-1];
         end
         if (redirect) mif.insn_ready = 1'b0;
         else redirect_pc = $urandom();
      end
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_error"}, 32'(error), 32'(err_exp));
      if (exp_done_edge >= 0) chk({tag, "_done_edge"}, 32'(i - 1), 32'(exp_done_edge));
      @(negedge clock);
      chk({tag, "_undelivered"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      redirect = 1'b0;
   endtask

   function automatic logic [31:0] rand_tgt();
      int unsigned r;
      r = $urandom_range(0, 19);
      if (r == 0) return START - 32'd4;
      if (r <= 2) return START + DEPTH - 32'd4 + 32'($urandom_range(0, 7));
      return START + 32'($urandom_range(0, DEPTH - 1));
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual time limit hit, required run to finish");
      $fatal(1);
   end

   initial begin
      mif.mem_busy   = 1'b0;
      mif.insn_ready = 1'b0;
      clear_plan();
      repeat (3) @(negedge clock);
      chk("rst_valid", 32'(mif.insn_valid), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_enable", 32'(mif.mem_enable), 32'd0);
      chk("rst_insn", mif.insn, 32'd0);
      chk("rst_insn_pc", mif.insn_pc, 32'd0);
      chk("rst_address", mif.mem_address, START);
      chk("rst_rw", 32'(mif.mem_rw), 32'd1);
      chk("rst_size", 32'(mif.mem_access_size), 32'd0);
      reset_n = 1'b1;

      ovr[START]       = 32'h1111_1111;
      ovr[START + 4]   = 32'h2222_2222;
      ovr[START + 8]   = 32'h3333_3333;
      do_run("basic", 3, 1'b0, 0, 0, 9);
      do_run("backpressure", 3, 1'b0, 5, 0, 14);
      do_run("busy", 3, 1'b0, 0, 2, 11);
      ovr.delete();

      ev_kind[1] = 2;
      ev_tgt[1]  = 32'h8002_0043;
      do_run("redir_resp", 3, 1'b0, 0, 0, 11);
      clear_plan();

      req_redir = 1'b1;
      req_tgt   = 32'h8012_0000;
      do_run("range", 2, 1'b0, 0, 0, 2);
      chk("range_no_access", 32'(accept_cnt), 32'd0);
      req_tgt   = START + DEPTH - 32'd4;
      do_run("last_word", 3, 1'b0, 0, 0, 5);
      clear_plan();

      do_run("zero", 0, 1'b0, 0, 0, 0);
      chk("zero_no_access", 32'(accept_cnt), 32'd0);

      // Reset while a word is held
      @(negedge clock);
      start = 1'b1;
      insn_count = 2;
      mif.insn_ready = 1'b0;
      mif.mem_busy = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         start = 1'b0;
         if (mif.insn_valid) break;
      end
      chk("hold_reached", 32'(mif.insn_valid), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(mif.insn_valid), 32'd0);
      chk("async_rst_done", 32'(done), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
      chk("post_rst_idle_enable", 32'(mif.mem_enable), 32'd0);
      chk("post_rst_address", mif.mem_address, START);
      chk("post_rst_done", 32'(done), 32'd0);

      for (int r = 0; r < 25; r++) begin
         clear_plan();
         for (int f = 0; f < 64; f++) begin
            int unsigned p;
            p = $urandom_range(0, 9);
            if (p == 0) ev_kind[f] = 2;
            else if (p == 1) ev_kind[f] = 3;
            ev_tgt[f] = rand_tgt();
         end
         req_redir = ($urandom_range(0, 5) == 0);
         req_tgt   = rand_tgt();
         do_run("random", int'($urandom_range(1, 8)), 1'b1, 0, 0, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
